dbi_decode_multilane: RTL and testbench
=======================================

# dbi_decode_multilane

Parametrised, multi-lane successor to the single-lane 4-bit DBI decoder. It decodes LANES independent DBI lanes per beat, each lane BW data bits plus one inversion flag, behind a one-stage valid/ready pipeline register. It also checks every received beat against the encoder's DC or AC invariant and keeps a saturating violation counter. It sits between the link receive register and the systolic-array input FIFOs.

## Interface
Parameters:
- BW, 4: data bits per lane. Even, and at least 2.
- LANES, 4: number of lanes decoded per beat.
- CW, 16: width of the violation counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- dbi_en  input  1  1 = apply inversion flags and check invariants; 0 = pass through.
- mode  input  1  0 = DBI-DC check; 1 = DBI-AC check.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- data_in  input  LANES*(BW+1)  lane i is at [i*(BW+1) +: BW+1]; its flag is the MSB of that slice.
- out_valid  output  1  data_out holds a decoded beat.
- out_ready  input  1  downstream accepts the beat.
- data_out  output  LANES*BW  lane i is at [i*BW +: BW].
- viol_clr  input  1  synchronous clear of viol_cnt.
- viol_cnt  output  CW  saturating count of lane violations.

## Operation
- Accept condition: acc = in_valid & in_ready, where in_ready = ~out_valid | out_ready. in_ready is combinational.
- dbi_en and mode are sampled only on the cycle of acc.
- Decode per lane, with d = data bits and f = flag:
  - dbi_en=1: output d when f=0, output ~d when f=1.
  - dbi_en=0: output d; f is ignored.
- prev[i] is a per-lane register holding the BW data bits last accepted on lane i, exactly as received (not decoded).
  - Updated on every acc, regardless of dbi_en.
  - Reset value is 0.
- Violation checks, evaluated only on acc with dbi_en=1:
  - mode=0 (DC): a lane violates when the number of zeros in d is greater than BW/2.
  - mode=1 (AC): a lane violates when popcount(d XOR prev[i]) is greater than BW/2.
- Counter update: on acc, viol_cnt += number of violating lanes (0..LANES), saturating at 2^CW-1.
- Clear priority: viol_clr=1 forces viol_cnt to 0 that cycle. Clear wins over a simultaneous increment.
- Output register behaviour:
  - On acc, data_out and out_valid=1 are loaded on the next edge.
  - If out_valid & out_ready & ~in_valid, out_valid falls to 0.
  - If out_valid & ~out_ready, data_out and out_valid hold.

## Timing
- Latency is 1 cycle from acc to out_valid/data_out.
- Throughput is 1 beat per cycle while out_ready=1.
- Reset values: out_valid=0, data_out=0, viol_cnt=0, all prev=0. in_ready is 1 after reset.
- Reset mid-operation: any pending output beat is dropped; no increment occurs on the reset cycle.
- Back-to-back transfers with out_ready=1 produce no bubble.
- AC history spans beats: the first beat after reset is compared against 0.
- Counter boundaries:
  - When saturated, viol_cnt stays at 2^CW-1.
  - A multi-lane increment that would overflow clamps to 2^CW-1.

## Test plan
1. DC decode and check. Defaults, dbi_en=1, mode=0, out_ready=1, one beat with data_in=0x84DE5 (lane3..0 = 1_0000, 1_0011, 0_1111, 0_0101).
   - Next cycle: data_out=0xFCF5, out_valid=1.
   - viol_cnt=1; only lane3 violates (4 zeros).
2. Pass-through. Same beat with dbi_en=0.
   - data_out=0x03F5.
   - viol_cnt unchanged.
3. AC check. mode=1, dbi_en=1, from reset.
   - Beat A = 0x00000: no violations.
   - Beat B = lane0 0_1111, other lanes 0: viol_cnt=1 (distance 4).
   - Beat C = lane0 0_1100, other lanes 0: no change (distance 2).
4. Backpressure. Hold out_ready=0 for 3 cycles after a beat lands, while driving in_valid=1 with a new beat.
   - in_ready=0 and data_out stable throughout.
   - When out_ready returns to 1: in_ready=1, the new beat is accepted, and it appears on data_out on the next cycle.
5. Saturation and clear. Build with CW=2 and feed 2 beats with 4 DC-violating lanes each (all lanes 1_0000).
   - viol_cnt=3 after beat 1 and stays 3.
   - viol_clr asserted together with a violating beat gives viol_cnt=0.
6. Reset mid-stream. Assert reset while out_valid=1 and out_ready=0.
   - Next cycle: out_valid=0, data_out=0, viol_cnt=0.
   - The next AC beat is compared against prev=0.

Source files
------------

// File: rtl/dbi_decode_multilane.sv
// Multi-lane DBI decoder behind a one-stage valid/ready register, with DC/AC
// invariant checking and a saturating per-lane violation counter.
module dbi_decode_multilane #(
  parameter int BW    = 4,
  parameter int LANES = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dbi_en,
  input  logic                     mode,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*(BW+1)-1:0]  data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*BW-1:0]      data_out,
  input  logic                     viol_clr,
  output logic [CW-1:0]            viol_cnt
);

  localparam int LW  = BW + 1;
  localparam int PCW = $clog2(BW + 1);
  localparam int NW  = $clog2(LANES + 1);
  localparam int SW  = CW + NW;

  function automatic logic [PCW-1:0] popcount(input logic [BW-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int k = 0; k < BW; k++) c = c + PCW'(v[k]);
    return c;
  endfunction

  // Widened add so a multi-lane increment near the top clamps instead of wrapping.
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [NW-1:0] n);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(n);
    if (s > SW'({CW{1'b1}})) return {CW{1'b1}};
    return s[CW-1:0];
  endfunction

  logic                      acc;
  logic                      vld_p1;
  logic [LANES*BW-1:0]       data_p1;
  logic [LANES-1:0][BW-1:0]  prev_p1;
  logic [CW-1:0]             cnt_p1;
  logic [LANES*BW-1:0]       dec_p0;
  logic [LANES-1:0]          viol_p0;
  logic [NW-1:0]             nviol_p0;

  assign in_ready = ~vld_p1 | out_ready;
  assign acc      = in_valid & in_ready;

  // Stage p0: per-lane decode and invariant check on the incoming beat
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [BW-1:0] d;
    logic          f;
    logic          dc_bad;
    logic          ac_bad;

    assign d      = data_in[g*LW +: BW];
    assign f      = data_in[g*LW + BW];
    assign dc_bad = popcount(~d) > PCW'(BW / 2);
    assign ac_bad = popcount(d ^ prev_p1[g]) > PCW'(BW / 2);

    assign dec_p0[g*BW +: BW] = (dbi_en & f) ? ~d : d;
    assign viol_p0[g]         = dbi_en & (mode ? ac_bad : dc_bad);
  end

  always_comb begin
    nviol_p0 = '0;
    for (int i = 0; i < LANES; i++) nviol_p0 = nviol_p0 + NW'(viol_p0[i]);
  end

  // Stage p1: output register, raw-data history and violation counter
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      prev_p1 <= '0;
      cnt_p1  <= '0;
    end else begin
      if (acc) begin
        vld_p1  <= 1'b1;
        data_p1 <= dec_p0;
        for (int i = 0; i < LANES; i++) prev_p1[i] <= data_in[i*LW +: BW];
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end

      if (viol_clr)  cnt_p1 <= '0;
      else if (acc)  cnt_p1 <= sat_add(cnt_p1, nviol_p0);
    end
  end

  assign out_valid = vld_p1;
  assign data_out  = data_p1;
  assign viol_cnt  = cnt_p1;

endmodule

// File: tb/tb_dbi_decode_multilane.sv
// Scoreboard bench for dbi_decode_multilane: directed beats push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_dbi_decode_multilane;

  logic        clk = 1'b0;
  logic        reset;
  logic        dbi_en, mode, in_valid, in_ready, out_valid, out_ready, viol_clr;
  logic [19:0] data_in;
  logic [15:0] data_out;
  logic [15:0] viol_cnt;

  logic        s_valid, s_rdy, s_ov, s_clr;
  logic [19:0] s_data;
  logic [15:0] s_out;
  logic [1:0]  s_cnt;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  dbi_decode_multilane #(.BW(4), .LANES(4), .CW(16)) dut (
    .clk(clk), .reset(reset), .dbi_en(dbi_en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .viol_clr(viol_clr), .viol_cnt(viol_cnt)
  );

  dbi_decode_multilane #(.BW(4), .LANES(4), .CW(2)) u_sat (
    .clk(clk), .reset(reset), .dbi_en(1'b1), .mode(1'b0),
    .in_valid(s_valid), .in_ready(s_rdy), .data_in(s_data),
    .out_valid(s_ov), .out_ready(1'b1), .data_out(s_out),
    .viol_clr(s_clr), .viol_cnt(s_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Monitor: compare each beat taken by the downstream side.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
      else chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [19:0] d, input logic en, input logic md);
    data_in  = d;
    dbi_en   = en;
    mode     = md;
    in_valid = 1'b1;
  endtask

  task automatic wait_acc(input logic [15:0] exp);
    bit got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dbi_en = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    viol_clr = 1'b0; data_in = '0;
    s_valid = 1'b0; s_clr = 1'b0; s_data = '0;
    idle(2);
    reset = 1'b0;

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out",  32'(data_out),  32'd0);
    chk("rst_viol_cnt",  32'(viol_cnt),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // DC decode and check
    drive(20'h84DE5, 1'b1, 1'b0); wait_acc(16'hFCF5);
    chk("dc_out_valid", 32'(out_valid), 32'd1);
    chk("dc_viol_cnt",  32'(viol_cnt),  32'd1);

    // Pass-through
    drive(20'h84DE5, 1'b0, 1'b0); wait_acc(16'h03F5);
    chk("pt_viol_cnt", 32'(viol_cnt), 32'd1);

    // AC check from reset
    idle(1); do_reset();
    drive(20'h00000, 1'b1, 1'b1); wait_acc(16'h0000);
    chk("ac_a_viol", 32'(viol_cnt), 32'd0);
    drive(20'h0000F, 1'b1, 1'b1); wait_acc(16'h000F);
    chk("ac_b_viol", 32'(viol_cnt), 32'd1);
    drive(20'h0000C, 1'b1, 1'b1); wait_acc(16'h000C);
    chk("ac_c_viol", 32'(viol_cnt), 32'd1);

    // Backpressure
    idle(2);
    out_ready = 1'b0;
    drive(20'h0000A, 1'b1, 1'b0); wait_acc(16'h000A);
    drive(20'h00003, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready",  32'(in_ready),  32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_data_hold", 32'(data_out),  32'h000A);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_resume", 32'(in_ready), 32'd1);
    wait_acc(16'h0003);
    chk("bp_new_beat", 32'(data_out), 32'h0003);

    // Saturation and clear on a 2-bit counter
    s_data = 20'h84210; s_valid = 1'b1;
    @(posedge clk); #1;
    chk("sat_rdy",    32'(s_rdy), 32'd1);
    chk("sat_ov",     32'(s_ov),  32'd1);
    chk("sat_out",    32'(s_out), 32'hFFFF);
    chk("sat_beat1",  32'(s_cnt), 32'd3);
    @(posedge clk); #1;
    chk("sat_beat2",  32'(s_cnt), 32'd3);
    s_clr = 1'b1;
    @(posedge clk); #1;
    chk("sat_clr_wins", 32'(s_cnt), 32'd0);
    s_clr = 1'b0; s_valid = 1'b0;

    // Reset mid-stream with a pending output beat
    idle(2);
    out_ready = 1'b0;
    drive(20'h00007, 1'b1, 1'b1); wait_acc(16'h0007);
    chk("mid_pending", 32'(out_valid), 32'd1);
    reset = 1'b1;
    drive(20'h80000, 1'b1, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_data_out",  32'(data_out),  32'd0);
    chk("mid_viol_cnt",  32'(viol_cnt),  32'd0);
    out_ready = 1'b1;
    drive(20'h00007, 1'b1, 1'b1); wait_acc(16'h0007);
    chk("mid_ac_vs_zero", 32'(viol_cnt), 32'd1);

    idle(3);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
